ascon_state_loader: RTL

Upstream feeder for the bit-serial one-round permutation. It accepts a parallel IV/key/nonce triple through a valid/ready handshake and serialises the five 64-bit state lanes MSB-first as a 5-bit-per-cycle stream. It also generates the serial round-constant bit for every round of an a=12 or b=6 permutation run. It replaces hand-driven lane and constant stimulus with a self-timed source locked to the permutation's round period.

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/ascon_rc_gen.sv | 31 +++
 rtl/ascon_state_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon state loader: round-constant table,
// lane/round sizes and the loader FSM state encoding.
package ascon_pkg;

    localparam int LANE_BITS = 64;
    localparam int NROUNDS_A = 12;
    localparam int NROUNDS_B = 6;

    // Entry 0 is the first constant of a 12-round run; a 6-round run starts at entry 6.
    localparam logic [95:0] RC_TABLE = 96'hf0_e1_d2_c3_b4_a5_96_87_78_69_5a_4b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] rc_entry(input logic [3:0] idx);
        logic [7:0] entry;
        entry = 8'h00;
        if (idx < 4'd12) begin
            entry = RC_TABLE[8 * (11 - int'(idx)) +: 8];
        end
        return entry;
    endfunction

endpackage

// File: rtl/ascon_rc_gen.sv
// Serial round-constant generator: emits the MSB-first constant byte of the
// current round in the 8-cycle window starting at CONST_OFFSET.
import ascon_pkg::*;

module ascon_rc_gen #(
    parameter int PC_W         = 9,
    parameter int CONST_OFFSET = 56
) (
    input  logic [3:0]      i_round_idx,
    input  logic            i_nrounds_12,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_const_bit
);

    logic [4:0]      w_tab_idx;
    logic [7:0]      w_entry;
    logic [PC_W-1:0] w_rel;
    logic [2:0]      w_bit_sel;
    logic            w_in_win;

    always_comb begin
        // Shorter runs use the tail of the table.
        w_tab_idx = {1'b0, i_round_idx} + (i_nrounds_12 ? 5'd0 : 5'(NROUNDS_A - NROUNDS_B));
        w_entry   = (w_tab_idx < 5'd12) ? rc_entry(w_tab_idx[3:0]) : 8'h00;
        w_rel     = i_pc - PC_W'(CONST_OFFSET);
        w_in_win  = (i_pc >= PC_W'(CONST_OFFSET)) && (w_rel < PC_W'(8));
        w_bit_sel = 3'd7 - w_rel[2:0];
        o_const_bit = w_in_win ? w_entry[w_bit_sel] : 1'b0;
    end

endmodule

// File: rtl/ascon_state_loader.sv
// Ascon state loader: accepts IV/key/nonce by handshake, streams the five lanes
// bit-serially and emits round constants. Macro ASCON_LOADER_CAPTURE_EN adds input capture registers.
import ascon_pkg::*;

module ascon_state_loader #(
    parameter int ROUND_PERIOD = 448,
    parameter int CONST_OFFSET = 56
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [63:0]  iv,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic         nrounds_12,
    output logic [4:0]   data_out,
    output logic         data_valid,
    output logic         const_bit,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    localparam int PC_W = $clog2(ROUND_PERIOD);

    state_t          r_state;
    state_t          w_nxt_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_nxt_pc;
    logic [3:0]      r_rc;
    logic [3:0]      w_nxt_rc;
    logic            r_nr12;
    logic            w_nxt_nr12;
    logic            w_pc_wrap;
    logic            w_last_round;
    logic [4:0]      w_lane_bits;
    logic            w_const_bit;
    logic            w_nxt_active;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_pc     = r_pc;
        w_nxt_rc     = r_rc;
        w_nxt_nr12   = r_nr12;
        w_pc_wrap    = (r_pc == PC_W'(ROUND_PERIOD - 1));
        w_last_round = (r_rc == (r_nr12 ? 4'(NROUNDS_A - 1) : 4'(NROUNDS_B - 1)));
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_nxt_state = ST_LOAD;
                    w_nxt_pc    = '0;
                    w_nxt_rc    = '0;
                    w_nxt_nr12  = nrounds_12;
                end
            end
            ST_LOAD, ST_RUN: begin
                if (w_pc_wrap) begin
                    w_nxt_pc = '0;
                    if (w_last_round) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_rc    = '0;
                    end else begin
                        w_nxt_state = ST_RUN;
                        w_nxt_rc    = r_rc + 4'd1;
                    end
                end else begin
                    w_nxt_pc = r_pc + PC_W'(1);
                    if (r_pc == PC_W'(LANE_BITS - 1)) begin
                        w_nxt_state = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_pc    = '0;
                w_nxt_rc    = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_pc    = '0;
                w_nxt_rc    = '0;
            end
        endcase
        w_nxt_active = (w_nxt_state == ST_LOAD) || (w_nxt_state == ST_RUN);
    end

`ifdef ASCON_LOADER_CAPTURE_EN
    logic [63:0] r_sh_x0;
    logic [63:0] r_sh_x1;
    logic [63:0] r_sh_x2;
    logic [63:0] r_sh_x3;
    logic [63:0] r_sh_x4;

    // Bit 63 goes out straight from the inputs at the handshake; the shifters hold the rest.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_lane_bits = {iv[63], key[127], key[63], nonce[127], nonce[63]};
        end else begin
            w_lane_bits = {r_sh_x0[63], r_sh_x1[63], r_sh_x2[63], r_sh_x3[63], r_sh_x4[63]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_x0 <= '0;
            r_sh_x1 <= '0;
            r_sh_x2 <= '0;
            r_sh_x3 <= '0;
            r_sh_x4 <= '0;
        end else if (r_state == ST_IDLE && load_valid) begin
            r_sh_x0 <= {iv[62:0], 1'b0};
            r_sh_x1 <= {key[126:64], 1'b0};
            r_sh_x2 <= {key[62:0], 1'b0};
            r_sh_x3 <= {nonce[126:64], 1'b0};
            r_sh_x4 <= {nonce[62:0], 1'b0};
        end else if (r_state == ST_LOAD) begin
            r_sh_x0 <= {r_sh_x0[62:0], 1'b0};
            r_sh_x1 <= {r_sh_x1[62:0], 1'b0};
            r_sh_x2 <= {r_sh_x2[62:0], 1'b0};
            r_sh_x3 <= {r_sh_x3[62:0], 1'b0};
            r_sh_x4 <= {r_sh_x4[62:0], 1'b0};
        end
    end
`else
    logic [5:0] w_lane_k;
    logic [6:0] w_hi_k;

    // Live inputs must be stable for the whole LOAD phase in this build.
    always_comb begin
        w_lane_k    = 6'd63 - w_nxt_pc[5:0];
        w_hi_k      = {1'b1, w_lane_k};
        w_lane_bits = {iv[w_lane_k], key[w_hi_k], key[{1'b0, w_lane_k}],
                       nonce[w_hi_k], nonce[{1'b0, w_lane_k}]};
    end
`endif

    ascon_rc_gen #(
        .PC_W         (PC_W),
        .CONST_OFFSET (CONST_OFFSET)
    ) u_rc_gen (
        .i_round_idx  (w_nxt_rc),
        .i_nrounds_12 (w_nxt_nr12),
        .i_pc         (w_nxt_pc),
        .o_const_bit  (w_const_bit)
    );

    // Outputs are registered from next-state values so they line up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_rc       <= '0;
            r_nr12     <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= 5'd0;
            const_bit  <= 1'b0;
            round_idx  <= 4'd0;
        end else begin
            r_state    <= w_nxt_state;
            r_pc       <= w_nxt_pc;
            r_rc       <= w_nxt_rc;
            r_nr12     <= w_nxt_nr12;
            load_ready <= (w_nxt_state == ST_IDLE);
            busy       <= (w_nxt_state != ST_IDLE);
            done       <= (w_nxt_state == ST_DONE);
            data_valid <= (w_nxt_state == ST_LOAD);
            data_out   <= (w_nxt_state == ST_LOAD) ? w_lane_bits : 5'd0;
            const_bit  <= w_nxt_active ? w_const_bit : 1'b0;
            round_idx  <= w_nxt_active ? w_nxt_rc : 4'd0;
        end
    end

endmodule
